approx_sub16_seq: RTL
=====================

Name: approx_sub16_seq

Overview:
- Digit-serial 16-bit subtractor. Computes diff = a - b, 4 bits per cycle, with valid/ready handshakes on both input and output.
- The lowest APPROX_BITS bits use an approximate, borrow-free cell, the subtractive counterpart of our approximate adder path.
- Used for pixel-difference and edge stages of the image pipeline.

Parameters:
- APPROX_BITS, 2, number of LSBs computed approximately. Legal range 0..4; 0 gives an exact subtractor.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept operands.
- a  in  16  minuend, unsigned.
- b  in  16  subtrahend, unsigned.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- diff  out  16  result, two's-complement 16-bit wrap.
- bout  out  1  borrow out of bit 15; 1 when a < b in the exact region.

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, diff=0, bout=0, digit counter=0, operand and accumulator registers=0.
- FSM states: IDLE, RUN, (NEG when ABS_DIFF_EN), DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch a, b, clear borrow and counter, go to RUN. No other state asserts in_ready; in_valid outside IDLE is ignored.
- RUN: one 4-bit digit per cycle, LSB digit first; counter 0..3.
  - Digit k: d[4k+3:4k] = a_dig - b_dig - borrow_in; borrow register updated.
  - After digit 3 (4th edge after accept): accumulated result copied to diff, borrow copied to bout, state goes to DONE.
- Approximate region (bits i < APPROX_BITS, all inside digit 0):
  - d[i] = a[i] XOR b[i].
  - No borrow generated within the region.
- Borrow into bit APPROX_BITS:
  - APPROX_BITS>0: (~a[APPROX_BITS-1]) & b[APPROX_BITS-1].
  - APPROX_BITS=0: 0.
- Exact region: standard ripple borrow within each digit; borrow between digits is carried in a register.
- diff/bout change only on entry to DONE (or NEG completion). They hold the previous result during RUN.
- DONE: out_valid=1, diff/bout stable. On out_ready go to IDLE and drop out_valid on that edge.
- Latency: accept edge E0, out_valid high after edge E4. Back-to-back throughput is 1 result per 6 cycles with out_ready tied high.
- out_ready low: stay in DONE indefinitely; diff/bout held.
- Reset mid-operation: any state goes immediately to the reset values; the partial result is discarded.
- Width: all internal arithmetic is 16-bit modulo 2^16; bit 16 is not exposed except via bout.
- APPROX_BITS outside 0..4: elaboration error.

Optional Feature:
- Macro: APPROX_SUB_ABS_DIFF_EN.
- Defined:
  - After RUN, if the final borrow=1, enter NEG for 1 cycle: diff = (~result)+1 computed exactly, then DONE. If borrow=0, go straight to DONE.
  - bout still reports the raw borrow.
  - Latency is 4 or 5 cycles.
- Undefined: NEG state absent; diff is the raw wrapped difference.

Decomposition:
- Package approx_sub_pkg: DIGIT_W=4, NUM_DIGITS=4, DATA_W=16, state enum type (IDLE/RUN/NEG/DONE).
- Sub-module sub_digit4:
  - Combinational 4-bit digit subtractor with inputs a_dig, b_dig, bin, and a 4-bit approx mask.
  - Outputs d_dig, bout.
  - Instantiated once and reused each RUN cycle.

Test Plan:
- APPROX_BITS=0, a=16, b=15, out_ready=1 -> diff=0x0001, bout=0; out_valid high 4 edges after accept, low 1 edge later.
- APPROX_BITS=2, a=16, b=15 -> diff=0x0003, bout=0 (approximation error of +2 checked against model).
- APPROX_BITS=0, a=11, b=18 -> diff=0xFFF9, bout=1. With APPROX_SUB_ABS_DIFF_EN -> diff=0x0007, bout=1, out_valid after 5 edges.
- Backpressure: result pending, out_ready=0 for 10 cycles, in_valid=1 with new operands -> diff/bout/out_valid stable, in_ready=0, new operands not captured. First result delivered when out_ready rises; second accepted next IDLE cycle.
- Reset at counter=2 in RUN -> same cycle: out_valid=0, in_ready=1, diff=0, bout=0. Next transaction a=0xFFFF, b=0x0001 (APPROX_BITS=0) -> diff=0xFFFE.
- Streaming 100 random pairs, in_valid and out_ready=1 -> one result per 6 cycles, every result matching the bit-accurate approximate reference model.

Source files
------------

// File: rtl/approx_sub_pkg.sv
// Shared sizes, FSM state type and approximation-mask helper for the
// digit-serial approximate subtractor.
package approx_sub_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int DATA_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One bit set per approximate LSB position inside the lowest digit.
    function automatic logic [DIGIT_W-1:0] approx_mask(input int n);
        logic [DIGIT_W-1:0] m;
        m = '0;
        for (int i = 0; i < DIGIT_W; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/sub_digit4.sv
// Combinational 4-bit digit subtractor; bits flagged in approx_mask use a
// borrow-free XOR cell that ignores the incoming borrow.
module sub_digit4
    import approx_sub_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_dig,
    input  logic [DIGIT_W-1:0] b_dig,
    input  logic               bin,
    input  logic [DIGIT_W-1:0] approx_mask,
    output logic [DIGIT_W-1:0] d_dig,
    output logic               bout
);

    // An approximate bit passes on only its own ~a&b, so just the topmost
    // approximate bit can feed a borrow into the exact region above it.
    always_comb begin
        logic [DIGIT_W:0] chain;
        chain    = '0;
        chain[0] = bin;
        d_dig    = '0;
        for (int i = 0; i < DIGIT_W; i++) begin
            if (approx_mask[i]) begin
                d_dig[i]     = a_dig[i] ^ b_dig[i];
                chain[i + 1] = ~a_dig[i] & b_dig[i];
            end else begin
                d_dig[i]     = a_dig[i] ^ b_dig[i] ^ chain[i];
                chain[i + 1] = (~a_dig[i] & b_dig[i]) | (~(a_dig[i] ^ b_dig[i]) & chain[i]);
            end
        end
        bout = chain[DIGIT_W];
    end

endmodule

// File: rtl/approx_sub16_seq.sv
// Digit-serial 16-bit subtractor with approximate LSBs and valid/ready on both
// sides. Define APPROX_SUB_ABS_DIFF_EN to return |a-b| via an extra NEG cycle.
module approx_sub16_seq
    import approx_sub_pkg::*;
#(
    parameter int APPROX_BITS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] diff,
    output logic              bout
);

    localparam logic [DIGIT_W-1:0] APPROX_MASK = approx_mask(APPROX_BITS);
    localparam logic [1:0]         LAST_DIGIT  = 2'(NUM_DIGITS - 1);

    generate
        if (APPROX_BITS < 0 || APPROX_BITS > DIGIT_W) begin : g_bad_approx_bits
            $error("approx_sub16_seq: APPROX_BITS must lie in 0..4");
        end
    endgenerate

    state_t              state;
    logic [1:0]          digit_cnt;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic [DATA_W-1:0]   acc;
    logic                borrow;

    logic [DIGIT_W-1:0]  dig_mask;
    logic [DIGIT_W-1:0]  dig_d;
    logic                dig_bout;

    // Operands shift right one digit per RUN cycle, so the single digit cell
    // always looks at the low nibble; the approximate mask applies to digit 0 only.
    assign dig_mask = (digit_cnt == 2'd0) ? APPROX_MASK : '0;

    sub_digit4 u_digit (
        .a_dig       (a_reg[DIGIT_W-1:0]),
        .b_dig       (b_reg[DIGIT_W-1:0]),
        .bin         (borrow),
        .approx_mask (dig_mask),
        .d_dig       (dig_d),
        .bout        (dig_bout)
    );

    // Results enter acc at the top and slide down, so after four digits
    // acc holds the full difference in natural bit order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            digit_cnt <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            borrow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        acc       <= '0;
                        borrow    <= 1'b0;
                        digit_cnt <= '0;
                        in_ready  <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    a_reg     <= {{DIGIT_W{1'b0}}, a_reg[DATA_W-1:DIGIT_W]};
                    b_reg     <= {{DIGIT_W{1'b0}}, b_reg[DATA_W-1:DIGIT_W]};
                    acc       <= {dig_d, acc[DATA_W-1:DIGIT_W]};
                    borrow    <= dig_bout;
                    digit_cnt <= digit_cnt + 2'd1;
                    if (digit_cnt == LAST_DIGIT) begin
`ifdef APPROX_SUB_ABS_DIFF_EN
                        if (dig_bout) begin
                            state <= NEG;
                        end else begin
                            diff      <= {dig_d, acc[DATA_W-1:DIGIT_W]};
                            bout      <= dig_bout;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
`else
                        diff      <= {dig_d, acc[DATA_W-1:DIGIT_W]};
                        bout      <= dig_bout;
                        out_valid <= 1'b1;
                        state     <= DONE;
`endif
                    end
                end
`ifdef APPROX_SUB_ABS_DIFF_EN
                NEG: begin
                    diff      <= ~acc + 16'd1;
                    bout      <= borrow;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
